// File: rtl/score_plot_pkg.sv
// Shared types and the 3x5 hex font for the score plotter.
// Glyph bit index is row*3 + col, row 0 at the top, col 0 at the left.
package score_plot_pkg;

    localparam int unsigned CELL_W     = 4;
    localparam int unsigned GLYPH_W    = 3;
    localparam int unsigned GLYPH_H    = 5;
    localparam int unsigned GLYPH_BITS = GLYPH_W * GLYPH_H;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    // Rows are written left-to-right as they look on screen; col 0 lands in the low bit.
    function automatic logic [2:0] rev3(input logic [2:0] row);
        return {row[0], row[1], row[2]};
    endfunction

    function automatic logic [GLYPH_BITS-1:0] mk_glyph(
        input logic [2:0] r0,
        input logic [2:0] r1,
        input logic [2:0] r2,
        input logic [2:0] r3,
        input logic [2:0] r4
    );
        return {rev3(r4), rev3(r3), rev3(r2), rev3(r1), rev3(r0)};
    endfunction

    localparam logic [GLYPH_BITS-1:0] GLYPHS [16] = '{
        mk_glyph(3'b111, 3'b101, 3'b101, 3'b101, 3'b111),
        mk_glyph(3'b010, 3'b110, 3'b010, 3'b010, 3'b111),
        mk_glyph(3'b111, 3'b001, 3'b111, 3'b100, 3'b111),
        mk_glyph(3'b111, 3'b001, 3'b111, 3'b001, 3'b111),
        mk_glyph(3'b101, 3'b101, 3'b111, 3'b001, 3'b001),
        mk_glyph(3'b111, 3'b100, 3'b111, 3'b001, 3'b111),
        mk_glyph(3'b111, 3'b100, 3'b111, 3'b101, 3'b111),
        mk_glyph(3'b111, 3'b001, 3'b001, 3'b001, 3'b001),
        mk_glyph(3'b111, 3'b101, 3'b111, 3'b101, 3'b111),
        mk_glyph(3'b111, 3'b101, 3'b111, 3'b001, 3'b111),
        mk_glyph(3'b111, 3'b101, 3'b111, 3'b101, 3'b101),
        mk_glyph(3'b110, 3'b101, 3'b110, 3'b101, 3'b110),
        mk_glyph(3'b111, 3'b100, 3'b100, 3'b100, 3'b111),
        mk_glyph(3'b110, 3'b101, 3'b101, 3'b101, 3'b110),
        mk_glyph(3'b111, 3'b100, 3'b111, 3'b100, 3'b111),
        mk_glyph(3'b111, 3'b100, 3'b111, 3'b100, 3'b100)
    };

    function automatic logic [GLYPH_BITS-1:0] glyph(input logic [3:0] nib);
        return GLYPHS[nib];
    endfunction

endpackage

// File: rtl/score_plot.sv
// Plots a two-hex-digit score as a scaled 3x5 font, one pixel per cycle,
// behind the start/waitrequest handshake shared by the screen plotters.
module score_plot
    import score_plot_pkg::*;
#(
    parameter logic [7:0]  X0    = 8'd120,
    parameter logic [6:0]  Y0    = 7'd2,
    parameter int unsigned SCALE = 2,
    parameter logic [2:0]  FG    = 3'b111,
    parameter logic [2:0]  BG    = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] score,
    output logic       waitrequest,
    output logic       vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour
);

    localparam logic [1:0] S_LAST = 2'(SCALE - 1);
    localparam logic [1:0] C_LAST = 2'(CELL_W - 1);
    localparam logic [2:0] R_LAST = 3'(GLYPH_H - 1);

    // The whole two-digit region must sit on the 160x120 screen.
    if (SCALE == 0 || SCALE > 4 ||
        (int'(X0) + 8 * int'(SCALE)) > 160 ||
        (int'(Y0) + 5 * int'(SCALE)) > 120) begin : g_bad_params
        $fatal(1, "score_plot: SCALE or screen region out of range");
    end

    state_t     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic       d_q,  d_d;
    logic [2:0] r_q,  r_d;
    logic [1:0] sy_q, sy_d;
    logic [1:0] c_q,  c_d;
    logic [1:0] sx_q, sx_d;
    logic       emit;
    logic       last_px;

    logic       plot_d;
    logic       wait_d;
    logic [7:0] x_d;
    logic [6:0] y_d;
    logic [2:0] col_d;

    logic [3:0]            nib;
    logic [GLYPH_BITS-1:0] bits;
    logic [3:0]            gidx;
    logic [8:0]            x9;
    logic [8:0]            y9;

    // Next state and next pixel position; counters hold the pixel being shown.
    always_comb begin : next_state
        state_d = state_q;
        score_d = score_q;
        d_d     = d_q;
        r_d     = r_q;
        sy_d    = sy_q;
        c_d     = c_q;
        sx_d    = sx_q;
        emit    = 1'b0;
        last_px = !d_q && (r_q == R_LAST) && (sy_q == S_LAST) &&
                  (c_q == C_LAST) && (sx_q == S_LAST);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAW;
                    score_d = score;
                    d_d     = 1'b1;
                    r_d     = 3'd0;
                    sy_d    = 2'd0;
                    c_d     = 2'd0;
                    sx_d    = 2'd0;
                    emit    = 1'b1;
                end
            end
            DRAW: begin
                if (last_px) begin
                    state_d = IDLE;
                end else begin
                    emit = 1'b1;
                    sx_d = sx_q + 2'd1;
                    if (sx_q == S_LAST) begin
                        sx_d = 2'd0;
                        c_d  = c_q + 2'd1;
                        if (c_q == C_LAST) begin
                            c_d  = 2'd0;
                            sy_d = sy_q + 2'd1;
                            if (sy_q == S_LAST) begin
                                sy_d = 2'd0;
                                r_d  = r_q + 3'd1;
                                if (r_q == R_LAST) begin
                                    r_d = 3'd0;
                                    d_d = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
        endcase
    end

    // Coordinates and colour of the pixel the next edge will present.
    always_comb begin : next_pixel
        nib  = d_d ? score_d[7:4] : score_d[3:0];
        bits = glyph(nib);
        gidx = 4'(32'(r_d) * GLYPH_W + 32'(c_d));
        x9   = 9'(X0) + (d_d ? 9'd0 : 9'(CELL_W * SCALE)) +
               9'(32'(c_d) * SCALE) + 9'(sx_d);
        y9   = 9'(Y0) + 9'(32'(r_d) * SCALE) + 9'(sy_d);

        plot_d = emit;
        wait_d = emit;
        x_d    = 8'd0;
        y_d    = 7'd0;
        col_d  = 3'd0;
        if (emit) begin
            x_d   = 8'(x9);
            y_d   = 7'(y9);
            col_d = ((c_d != C_LAST) && bits[gidx]) ? FG : BG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q     <= IDLE;
            score_q     <= 8'd0;
            d_q         <= 1'b0;
            r_q         <= 3'd0;
            sy_q        <= 2'd0;
            c_q         <= 2'd0;
            sx_q        <= 2'd0;
            waitrequest <= 1'b0;
            vga_plot    <= 1'b0;
            vga_x       <= 8'd0;
            vga_y       <= 7'd0;
            vga_colour  <= 3'd0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            d_q         <= d_d;
            r_q         <= r_d;
            sy_q        <= sy_d;
            c_q         <= c_d;
            sx_q        <= sx_d;
            waitrequest <= wait_d;
            vga_plot    <= plot_d;
            vga_x       <= x_d;
            vga_y       <= y_d;
            vga_colour  <= col_d;
        end
    end

endmodule
